// File: rtl/data_stack.sv
// Hardware data stack: top two cells held in registers, deeper cells in a
// single-port array; one op per cycle, every output registered.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPL    = 3'b011;
  localparam logic [2:0] OP_POPREPL = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_OVER    = 3'b110;

  logic [WIDTH-1:0] tos_q, nos_q, tos_n, nos_n;
  logic [DW-1:0]    depth_q, depth_n;
  logic             empty_q, full_q, ovf_q, unf_q;
  logic             ovf_e, unf_e;

  // Spill array holds cells below nos; cell k (0 = bottom) lives at index k.
  logic [WIDTH-1:0] mem [DEPTH-2];
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] rd_data;

  logic has1, has2, has3, room;

  assign has1 = (depth_q != '0);
  assign has2 = (depth_q >= DW'(2));
  assign has3 = (depth_q >= DW'(3));
  assign room = (depth_q != DW'(DEPTH));

  // One address per cycle: spill slot on a growing op, else the cell under nos.
  assign mem_addr = mem_we ? AW'(depth_q - DW'(2)) : AW'(depth_q - DW'(3));
  assign rd_data  = mem[mem_addr];

  always_comb begin
    tos_n   = tos_q;
    nos_n   = nos_q;
    depth_n = depth_q;
    mem_we  = 1'b0;
    ovf_e   = 1'b0;
    unf_e   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (room) begin
          tos_n   = din;
          nos_n   = tos_q;
          depth_n = depth_q + DW'(1);
          mem_we  = has2;
        end else begin
          ovf_e = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) begin
          tos_n   = nos_q;
          nos_n   = has3 ? rd_data : '0;
          depth_n = depth_q - DW'(1);
        end else begin
          unf_e = 1'b1;
        end
      end
      OP_REPL: begin
        if (has1) tos_n = din;
        else      unf_e = 1'b1;
      end
      OP_POPREPL: begin
        if (has2) begin
          tos_n   = din;
          nos_n   = has3 ? rd_data : '0;
          depth_n = depth_q - DW'(1);
        end else begin
          unf_e = 1'b1;
        end
      end
      OP_SWAP: begin
        if (has2) begin
          tos_n = nos_q;
          nos_n = tos_q;
        end else begin
          unf_e = 1'b1;
        end
      end
      OP_OVER: begin
        if (!has2) begin
          unf_e = 1'b1;
        end else if (!room) begin
          ovf_e = 1'b1;
        end else begin
          tos_n   = nos_q;
          nos_n   = tos_q;
          depth_n = depth_q + DW'(1);
          mem_we  = 1'b1;
        end
      end
      OP_NOP:  ;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst && mem_we) mem[mem_addr] <= nos_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_n;
      nos_q   <= nos_n;
      depth_q <= depth_n;
      empty_q <= (depth_n == '0);
      full_q  <= (depth_n == DW'(DEPTH));
      // A new error in the same cycle as clr_err keeps its flag set.
      ovf_q   <= ovf_e | (ovf_q & ~clr_err);
      unf_q   <= unf_e | (unf_q & ~clr_err);
    end
  end

  assign tos   = tos_q;
  assign nos   = nos_q;
  assign depth = depth_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed scenarios plus random op
// streams compared against a queue-based stack model.
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic             Clk;
  logic             Rst;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] tos, nos;
  logic [DW-1:0]    depth;
  logic             empty, full, ovf, unf;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .op(op), .din(din), .clr_err(clr_err),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // reference model: queue with the top of stack at the back
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf, m_unf;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_tos();
    return (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_nos();
    return (exp_q.size() > 1) ? exp_q[exp_q.size()-2] : '0;
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic [WIDTH-1:0] d,
                             input logic c, input logic r);
    int n;
    logic eo, eu;
    logic [WIDTH-1:0] a, b;
    n  = exp_q.size();
    eo = 1'b0;
    eu = 1'b0;
    if (r) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    case (o)
      3'd1: if (n < DEPTH) exp_q.push_back(d); else eo = 1'b1;
      3'd2: if (n >= 1) a = exp_q.pop_back(); else eu = 1'b1;
      3'd3: if (n >= 1) exp_q[n-1] = d; else eu = 1'b1;
      3'd4: if (n >= 2) begin
              a = exp_q.pop_back();
              b = exp_q.pop_back();
              exp_q.push_back(d);
            end else eu = 1'b1;
      3'd5: if (n >= 2) begin
              a = exp_q[n-1];
              exp_q[n-1] = exp_q[n-2];
              exp_q[n-2] = a;
            end else eu = 1'b1;
      3'd6: if (n < 2) eu = 1'b1;
            else if (n == DEPTH) eo = 1'b1;
            else exp_q.push_back(exp_q[n-2]);
      default: ;
    endcase
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (eo) m_ovf = 1'b1;
    if (eu) m_unf = 1'b1;
  endtask

  task automatic check_all();
    check("tos",   32'(tos),   32'(m_tos()));
    check("nos",   32'(nos),   32'(m_nos()));
    check("depth", 32'(depth), 32'(exp_q.size()));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full",  32'(full),  32'(exp_q.size() == DEPTH));
    check("ovf",   32'(ovf),   32'(m_ovf));
    check("unf",   32'(unf),   32'(m_unf));
  endtask

  // driver: apply one cycle of inputs, update model at the edge, check after it
  task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d,
                      input logic c = 1'b0, input logic r = 1'b0);
    op      = o;
    din     = d;
    clr_err = c;
    Rst     = r;
    @(posedge Clk);
    model_apply(o, d, c, r);
    #1;
    check_all();
  endtask

  int i;
  int phase;

  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    op = 3'd0; din = '0; clr_err = 1'b0; Rst = 1'b1;

    // reset state
    step(3'd1, 16'h1234, 1'b1, 1'b1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_depth", 32'(depth), 32'd0);

    // three pushes then two pops
    step(3'd1, 16'h0011);
    step(3'd1, 16'h0022);
    step(3'd1, 16'h0033);
    check("push3_tos", 32'(tos), 32'h33);
    check("push3_nos", 32'(nos), 32'h22);
    step(3'd2, '0);
    step(3'd2, '0);
    check("pop2_tos", 32'(tos), 32'h11);
    check("pop2_nos", 32'(nos), 32'h0);

    // popreplace / swap / over from depth 3
    step(3'd1, 16'h0022);
    step(3'd1, 16'h0033);
    step(3'd4, 16'h0055);
    check("poprepl_nos", 32'(nos), 32'h11);
    step(3'd5, '0);
    check("swap_tos", 32'(tos), 32'h11);
    step(3'd6, '0);
    check("over_tos", 32'(tos), 32'h55);
    check("over_depth", 32'(depth), 32'd3);

    // fill to capacity, overflow, drain in order
    step(3'd0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= DEPTH; k++) step(3'd1, WIDTH'(k));
    check("fill_full", 32'(full), 32'd1);
    step(3'd1, 16'hFFFF);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_tos", 32'(tos), 32'(DEPTH));
    step(3'd6, '0);
    for (int k = DEPTH; k >= 1; k--) begin
      check("drain_tos", 32'(tos), 32'(k));
      step(3'd2, '0);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // underflow and clear priority
    step(3'd0, '0, 1'b0, 1'b1);
    step(3'd2, '0);
    check("unf_set", 32'(unf), 32'd1);
    step(3'd1, 16'h0007);
    step(3'd5, '0, 1'b1);
    check("unf_err_wins", 32'(unf), 32'd1);
    step(3'd0, '0, 1'b1);
    check("unf_cleared", 32'(unf), 32'd0);

    // reset mid-sequence discards contents
    for (int k = 0; k < DEPTH; k++) step(3'd1, WIDTH'(16'h100 + k));
    step(3'd1, 16'h0BAD);
    for (int k = 0; k < DEPTH - 5; k++) step(3'd2, '0);
    check("pre_rst_depth", 32'(depth), 32'd5);
    step(3'd1, 16'h0BEE, 1'b0, 1'b1);
    check("rst_ovf", 32'(ovf), 32'd0);
    step(3'd1, 16'h00AA);
    check("post_rst_nos", 32'(nos), 32'd0);

    // randomized op streams, phases bias the depth up or down
    for (i = 0; i < 3000; i++) begin
      logic [2:0] o;
      int sel;
      phase = (i / 150) % 3;
      sel = $urandom_range(0, 99);
      if (phase == 0)      o = (sel < 55) ? 3'd1 : 3'($urandom_range(0, 7));
      else if (phase == 1) o = (sel < 55) ? 3'd2 : 3'($urandom_range(0, 7));
      else                 o = 3'($urandom_range(0, 7));
      step(o, WIDTH'($urandom),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data cell width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning maximum number of cells held (DEPTH >= 4, power of two).
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port op  input  3  stack operation for this cycle (encoding in REQ-013).
REQ-006 SHALL have port din  input  WIDTH  data for PUSH, REPL and POPREPL.
REQ-007 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-008 SHALL have port tos  output  WIDTH  top-of-stack cell; 0 when depth = 0.
REQ-009 SHALL have port nos  output  WIDTH  next-on-stack cell; 0 when depth < 2.
REQ-010 SHALL have port depth  output  $clog2(DEPTH)+1  number of valid cells.
REQ-011 SHALL have ports empty, full  output  1 each  depth = 0, depth = DEPTH.
REQ-012 SHALL have ports ovf, unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-013 SHALL decode op: 000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 POPREPL, 101 SWAP, 110 OVER, 111 treated as NOP.
REQ-014 SHALL make every output a registered value; an op sampled at edge N is visible on tos/nos/depth/flags immediately after edge N (1-cycle latency, no combinational path from op/din to outputs).
REQ-015 SHALL accept one op per cycle with no stall; back-to-back ops of any mix SHALL each take effect exactly once.
REQ-016 PUSH: new tos = din, new nos = old tos, depth +1; valid when depth < DEPTH.
REQ-017 POP: new tos = old nos, new nos = cell below old nos (or 0), depth -1; valid when depth >= 1.
REQ-018 REPL: tos = din, depth and nos unchanged; valid when depth >= 1.
REQ-019 POPREPL (binary ALU result): old tos and nos removed, din pushed; new tos = din, nos = third cell (or 0), depth -1; valid when depth >= 2.
REQ-020 SWAP: tos and nos exchanged, depth unchanged; valid when depth >= 2.
REQ-021 OVER: push copy of old nos; new tos = old nos, new nos = old tos, depth +1; valid when 2 <= depth < DEPTH.
REQ-022 An op whose depth precondition fails SHALL leave all stack contents and depth unchanged.
REQ-023 A failed op needing more cells than present (POP/REPL at depth 0; POPREPL/SWAP/OVER at depth < 2) SHALL set unf; a failed PUSH/OVER at depth = DEPTH SHALL set ovf.
REQ-024 ovf and unf SHALL stay set until clr_err = 1 or Rst; if clr_err and a new error occur in the same cycle, the new error flag SHALL be set (error wins); clr_err SHALL not affect stack contents.
REQ-025 Cells below nos SHALL be preserved unaltered across any sequence of ops until popped; pointer arithmetic SHALL not wrap (depth saturates at 0 and DEPTH by REQ-022).
REQ-026 Internal storage beyond tos/nos SHALL be a single-port array of DEPTH-2 cells written/read at most once per cycle.

Reset
REQ-027 When Rst = 1 at a rising edge: depth = 0, tos = 0, nos = 0, empty = 1, full = 0, ovf = 0, unf = 0; op and clr_err ignored that cycle.
REQ-028 Reset mid-sequence SHALL discard all contents; array contents need not be cleared but SHALL never be visible after reset until re-pushed.

Verification
REQ-029 Reset, then PUSH 0x0011, PUSH 0x0022, PUSH 0x0033 on consecutive cycles -> tos = 0x0033, nos = 0x0022, depth = 3; then POP, POP -> tos = 0x0011, nos = 0, depth = 1.
REQ-030 Depth 3 (0x0011, 0x0022, 0x0033 top): POPREPL din = 0x0055 -> tos = 0x0055, nos = 0x0011, depth = 2; SWAP -> tos = 0x0011, nos = 0x0055; OVER -> tos = 0x0055, nos = 0x0011, depth = 3.
REQ-031 Push DEPTH cells 1..DEPTH -> full = 1, tos = DEPTH; extra PUSH 0xFFFF -> ovf = 1, tos = DEPTH, depth = DEPTH; then DEPTH POPs return DEPTH..1 in order and end with empty = 1.
REQ-032 From empty: POP -> unf = 1, depth = 0; clr_err asserted in same cycle as SWAP at depth 1 -> unf remains 1; clr_err alone next cycle -> unf = 0.
REQ-033 Depth 5 with ovf = 1, Rst asserted one cycle alongside PUSH -> depth = 0, tos = 0, ovf = 0, empty = 1; following PUSH 0x00AA -> tos = 0x00AA, nos = 0, depth = 1.
